// File: rtl/sram_sync_param_if.sv
// =============================================================================
// sram_sync_param_if : request/response bundle for the sram_sync_param memory
// Revision 1.0 - initial release
// =============================================================================
`default_nettype none

interface sram_sync_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic                  cs;
  logic                  rws;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     din;
  logic [DATA_W/8-1:0]   be;
  logic [DATA_W-1:0]     dout;
  logic                  rd_valid;
  logic                  rdy;
  logic                  err;

  modport master (
    output cs, rws, addr, din, be,
    input  dout, rd_valid, rdy, err
  );

  modport slave (
    input  cs, rws, addr, din, be,
    output dout, rd_valid, rdy, err
  );
endinterface

`default_nettype wire

// File: rtl/sram_sync_param.sv
// =============================================================================
// sram_sync_param : synchronous single-port SRAM with byte-lane writes,
//                   1/2-cycle read latency, range check and post-reset clear
// Revision 1.0 - initial release
// =============================================================================
`default_nettype none

module sram_sync_param #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 10,
  parameter int                DEPTH    = 1000,
  parameter int                RD_LAT   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  sram_sync_param_if.slave  bus
);

  localparam int                NUM_LANES = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     cnt_q, cnt_d;

  logic [DATA_W-1:0]     mem [DEPTH];

  logic                  rdy;
  logic                  acc;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  in_range;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_waddr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [NUM_LANES-1:0]  mem_wmask;
  logic [DATA_W-1:0]     rd_word;

  logic                  s1_vld_q, s1_vld_d;
  logic [DATA_W-1:0]     s1_data_q, s1_data_d;
  logic                  err_q, err_d;

  // ---------------------------------------------------------------------------
  // Clear sequencer: walks 0..DEPTH-1 once, then parks in READY until reset
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_CLEAR: begin
        if (cnt_q == LAST_IDX) begin
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rdy = (state_q == ST_READY);

  // ---------------------------------------------------------------------------
  // Access decode and single write-port arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    acc       = bus.cs && rdy;
    in_range  = ({1'b0, bus.addr} < DEPTH_EXT);
    wr_acc    = acc && bus.rws;
    rd_acc    = acc && !bus.rws;

    mem_we    = 1'b0;
    mem_waddr = bus.addr;
    mem_wdata = bus.din;
    mem_wmask = bus.be;

    if (state_q == ST_CLEAR) begin
      // rst_n gating keeps the array untouched by edges that occur during reset
      mem_we    = rst_n;
      mem_waddr = cnt_q;
      mem_wdata = INIT_VAL;
      mem_wmask = '1;
    end else begin
      mem_we    = wr_acc && in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (mem_wmask[i]) begin
          mem[mem_waddr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // First read stage and error flag (common to both latencies)
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_word   = in_range ? mem[bus.addr] : '0;
    s1_vld_d  = rd_acc;
    s1_data_d = rd_acc ? rd_word : s1_data_q;
    err_d     = acc && !in_range;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_data_q <= s1_data_d;
      err_q     <= err_d;
    end
  end

  assign bus.rdy = rdy;
  assign bus.err = err_q;

  // ---------------------------------------------------------------------------
  // Output stage selection
  // ---------------------------------------------------------------------------
  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              s2_vld_q, s2_vld_d;
      logic [DATA_W-1:0] s2_data_q, s2_data_d;

      always_comb begin
        s2_vld_d  = s1_vld_q;
        s2_data_d = s1_vld_q ? s1_data_q : s2_data_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_vld_q  <= 1'b0;
          s2_data_q <= '0;
        end else begin
          s2_vld_q  <= s2_vld_d;
          s2_data_q <= s2_data_d;
        end
      end

      assign bus.dout     = s2_data_q;
      assign bus.rd_valid = s2_vld_q;
    end else begin : g_lat1
      // s1_data_q only loads on accepted reads, so it already holds between pulses
      assign bus.dout     = s1_data_q;
      assign bus.rd_valid = s1_vld_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_sram_sync_param.sv
// =============================================================================
// tb_sram_sync_param : directed bench for two sram_sync_param configurations
// Revision 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_sram_sync_param;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  sram_sync_param_if #(.DATA_W(8),  .ADDR_W(10)) bus_a ();
  sram_sync_param_if #(.DATA_W(32), .ADDR_W(10)) bus_b ();

  // A: default geometry, B: 32-bit, full depth, two-cycle latency, non-zero init
  sram_sync_param #(
    .DATA_W(8), .ADDR_W(10), .DEPTH(1000), .RD_LAT(1), .INIT_VAL(8'h00)
  ) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  sram_sync_param #(
    .DATA_W(32), .ADDR_W(10), .DEPTH(1024), .RD_LAT(2), .INIT_VAL(32'hDEAD_BEEF)
  ) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  typedef struct {
    logic       cs;
    logic       rws;
    logic [9:0] addr;
    logic [7:0] din;
    logic       be;
    logic       exp_vld;
    logic [7:0] exp_dout;
    logic       exp_err;
  } vec_t;

  localparam int NVEC = 20;
  vec_t tbl [NVEC];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drv_a(input logic cs, input logic rws, input logic [9:0] addr,
                       input logic [7:0] din, input logic be);
    bus_a.cs = cs; bus_a.rws = rws; bus_a.addr = addr; bus_a.din = din; bus_a.be = be;
  endtask

  task automatic drv_b(input logic cs, input logic rws, input logic [9:0] addr,
                       input logic [31:0] din, input logic [3:0] be);
    bus_b.cs = cs; bus_b.rws = rws; bus_b.addr = addr; bus_b.din = din; bus_b.be = be;
  endtask

  // Counts clock edges until rdy rises on each instance while hammering both
  // with accesses that must be ignored during the clear.
  task automatic wait_clear(input string tag);
    int na  = 0;
    int nb  = 0;
    int bad = 0;
    drv_a(1'b1, 1'b0, 10'd1000, 8'h00, 1'b1);
    drv_b(1'b1, 1'b1, 10'd10, 32'hFFFF_FFFF, 4'hF);
    for (int n = 1; n <= 2000 && (na == 0 || nb == 0); n++) begin
      step();
      if (na == 0) begin
        if (bus_a.rd_valid || bus_a.err) bad++;
        if (bus_a.rdy) begin na = n; drv_a(1'b0, 1'b0, 10'd0, 8'h00, 1'b0); end
      end
      if (nb == 0) begin
        if (bus_b.rd_valid || bus_b.err) bad++;
        if (bus_b.rdy) begin nb = n; drv_b(1'b0, 1'b0, 10'd0, 32'h0, 4'h0); end
      end
    end
    chk({tag, "_a_clear_cycles"}, 32'(na), 32'd1000);
    chk({tag, "_b_clear_cycles"}, 32'(nb), 32'd1024);
    chk({tag, "_ignored_access_outputs"}, 32'(bad), 32'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    //            cs    rws   addr     din    be    vld   dout   err
    tbl[0]  = '{1'b1, 1'b0, 10'd10,   8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 10'd10,   8'h64, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 10'd20,   8'hC8, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 10'd999,  8'h01, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 10'd20,   8'h00, 1'b0, 1'b1, 8'hC8, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 10'd10,   8'h00, 1'b0, 1'b1, 8'h64, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 10'd999,  8'h00, 1'b0, 1'b1, 8'h01, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 10'd20,   8'h00, 1'b0, 1'b0, 8'h01, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 10'd1000, 8'h55, 1'b1, 1'b0, 8'h01, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 10'd1000, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 10'd999,  8'h00, 1'b0, 1'b1, 8'h01, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 10'd30,   8'hAA, 1'b0, 1'b0, 8'h01, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 10'd30,   8'h00, 1'b0, 1'b1, 8'h00, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 10'd30,   8'h3C, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 10'd30,   8'h00, 1'b0, 1'b1, 8'h3C, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 10'd30,   8'hFF, 1'b1, 1'b0, 8'h3C, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 10'd30,   8'h00, 1'b0, 1'b1, 8'h3C, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 10'd1023, 8'h77, 1'b1, 1'b0, 8'h3C, 1'b1};
    tbl[18] = '{1'b1, 1'b0, 10'd1023, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1};
    tbl[19] = '{1'b1, 1'b0, 10'd0,    8'h00, 1'b0, 1'b1, 8'h00, 1'b0};

    drv_a(1'b0, 1'b0, 10'd0, 8'h00, 1'b0);
    drv_b(1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_a_rdy",      32'(bus_a.rdy),      32'd0);
    chk("rst_a_rd_valid", 32'(bus_a.rd_valid), 32'd0);
    chk("rst_a_dout",     32'(bus_a.dout),     32'd0);
    chk("rst_a_err",      32'(bus_a.err),      32'd0);
    chk("rst_b_rdy",      32'(bus_b.rdy),      32'd0);
    chk("rst_b_dout",     bus_b.dout,          32'd0);

    rst_n = 1'b1;
    wait_clear("clr1");

    // Instance A: table of single-cycle-latency transactions
    for (int i = 0; i < NVEC; i++) begin
      drv_a(tbl[i].cs, tbl[i].rws, tbl[i].addr, tbl[i].din, tbl[i].be);
      step();
      chk($sformatf("vec%0d_rd_valid", i), 32'(bus_a.rd_valid), 32'(tbl[i].exp_vld));
      chk($sformatf("vec%0d_dout", i),     32'(bus_a.dout),     32'(tbl[i].exp_dout));
      chk($sformatf("vec%0d_err", i),      32'(bus_a.err),      32'(tbl[i].exp_err));
    end
    drv_a(1'b0, 1'b0, 10'd0, 8'h00, 1'b0);

    // Instance B: latency 2, clear value, writes during clear were dropped
    drv_b(1'b1, 1'b0, 10'd10, 32'h0, 4'h0);
    step();
    chk("b_lat2_first_edge_vld", 32'(bus_b.rd_valid), 32'd0);
    drv_b(1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
    step();
    chk("b_lat2_vld",  32'(bus_b.rd_valid), 32'd1);
    chk("b_init_dout", bus_b.dout,          32'hDEAD_BEEF);
    step();
    chk("b_lat2_pulse_end", 32'(bus_b.rd_valid), 32'd0);
    chk("b_dout_hold",      bus_b.dout,          32'hDEAD_BEEF);

    // Byte lanes plus read on the cycle right after the write
    drv_b(1'b1, 1'b1, 10'd5, 32'hAABB_CCDD, 4'hF);
    step();
    drv_b(1'b1, 1'b1, 10'd5, 32'h1122_3344, 4'b0101);
    step();
    drv_b(1'b1, 1'b0, 10'd5, 32'h0, 4'h0);
    step();
    chk("b_raw_first_edge_vld", 32'(bus_b.rd_valid), 32'd0);
    drv_b(1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
    step();
    chk("b_be_merge_vld",  32'(bus_b.rd_valid), 32'd1);
    chk("b_be_merge_dout", bus_b.dout,          32'hAA22_CC44);

    // Full-depth instance: addr 1000 is real storage, err stays low
    drv_b(1'b1, 1'b1, 10'd1000, 32'h1234_5678, 4'hF);
    step();
    chk("b_wr1000_err", 32'(bus_b.err), 32'd0);
    drv_b(1'b1, 1'b0, 10'd1000, 32'h0, 4'h0);
    step();
    chk("b_rd1000_err", 32'(bus_b.err), 32'd0);
    drv_b(1'b1, 1'b0, 10'd5, 32'h0, 4'h0);
    step();
    chk("b_pipe0_vld",  32'(bus_b.rd_valid), 32'd1);
    chk("b_pipe0_dout", bus_b.dout,          32'h1234_5678);
    drv_b(1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
    step();
    chk("b_pipe1_vld",  32'(bus_b.rd_valid), 32'd1);
    chk("b_pipe1_dout", bus_b.dout,          32'hAA22_CC44);
    step();
    chk("b_pipe_end_vld", 32'(bus_b.rd_valid), 32'd0);

    // Reset with reads in flight: flushed asynchronously, array re-cleared
    drv_a(1'b1, 1'b0, 10'd10, 8'h00, 1'b0);
    drv_b(1'b1, 1'b0, 10'd5, 32'h0, 4'h0);
    step();
    rst_n = 1'b0;
    #1;
    chk("inflight_a_vld",  32'(bus_a.rd_valid), 32'd0);
    chk("inflight_a_dout", 32'(bus_a.dout),     32'd0);
    chk("inflight_b_vld",  32'(bus_b.rd_valid), 32'd0);
    step();
    step();
    chk("inflight_b_vld_late", 32'(bus_b.rd_valid), 32'd0);
    chk("inflight_b_rdy",      32'(bus_b.rdy),      32'd0);
    rst_n = 1'b1;
    wait_clear("clr2");

    drv_a(1'b1, 1'b0, 10'd10, 8'h00, 1'b0);
    drv_b(1'b1, 1'b0, 10'd5, 32'h0, 4'h0);
    step();
    chk("reclr_a_vld",  32'(bus_a.rd_valid), 32'd1);
    chk("reclr_a_dout", 32'(bus_a.dout),     32'd0);
    drv_a(1'b0, 1'b0, 10'd0, 8'h00, 1'b0);
    drv_b(1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
    step();
    chk("reclr_b_vld",  32'(bus_b.rd_valid), 32'd1);
    chk("reclr_b_dout", bus_b.dout,          32'hDEAD_BEEF);

    // Reset halfway through the clear: full DEPTH cycles again afterwards
    drv_a(1'b1, 1'b1, 10'd10, 8'h5A, 1'b1);
    step();
    drv_a(1'b0, 1'b0, 10'd0, 8'h00, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (500) step();
    rst_n = 1'b0;
    #1;
    chk("midclr_a_rdy", 32'(bus_a.rdy), 32'd0);
    step();
    rst_n = 1'b1;
    wait_clear("clr3");

    drv_a(1'b1, 1'b0, 10'd10, 8'h00, 1'b0);
    step();
    chk("midclr_a_addr10", 32'(bus_a.dout), 32'd0);
    drv_a(1'b0, 1'b0, 10'd0, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
